// File: rtl/cycle_csr_ctrl.sv
// ---------------------------------------------------------------------------
// cycle_csr_ctrl
//   Control and CSR front-end for the 64-bit cycle counter.
//   - Drives the counter's clear and keep inputs from pipeline stall and CTRL.
//   - Serves 32-bit CSR reads of the 64-bit count. Reading CYCLE latches the
//     upper half into a shadow register, so a following CYCLEH read returns
//     a value that is coherent with the low half.
//   - Holds a 64-bit compare value and raises a sticky timer interrupt.
//
// Ports
//   clk          in   1   clock
//   rst          in   1   asynchronous, active-high reset
//   stall        in   1   pipeline stall; the counter holds while it is high
//   csr_rd_en    in   1   CSR read strobe, one cycle per access
//   csr_wr_en    in   1   CSR write strobe, one cycle per access
//   csr_addr     in   12  CSR address
//   csr_wdata    in   32  CSR write data
//   count        in   64  current counter value
//   count_clear  out  1   counter clear, one-cycle registered pulse
//   count_keep   out  1   counter hold (combinational)
//   csr_rdata    out  32  registered read data
//   csr_rd_valid out  1   high one cycle after a read strobe
//   cmp_irq      out  1   timer interrupt level (pending & irq_en, registered)
// ---------------------------------------------------------------------------
module cycle_csr_ctrl #(
   parameter logic [11:0] ADDR_CYCLE  = 12'hC00,
   parameter logic [11:0] ADDR_CYCLEH = 12'hC80,
   parameter logic [11:0] ADDR_CMPL   = 12'h7C0,
   parameter logic [11:0] ADDR_CMPH   = 12'h7C1,
   parameter logic [11:0] ADDR_CTRL   = 12'h7C2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        csr_rd_en,
   input  logic        csr_wr_en,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   input  logic [63:0] count,
   output logic        count_clear,
   output logic        count_keep,
   output logic [31:0] csr_rdata,
   output logic        csr_rd_valid,
   output logic        cmp_irq
);

   logic        inhibit;
   logic        irq_en;
   logic        pending;
   logic [63:0] cmp;
   logic [31:0] shadow;
   logic        shadow_valid;

   logic        wr_ctrl_p0;
   logic        wr_cmpl_p0;
   logic        wr_cmph_p0;
   logic        rd_cycle_p0;
   logic        rd_cycleh_p0;
   logic        match_p0;
   logic [31:0] ctrl_view_p0;
   logic [31:0] rd_mux_p0;

   // ---- stage p0: decode, compare and read mux (all from current-cycle values)
   assign wr_ctrl_p0   = csr_wr_en && (csr_addr == ADDR_CTRL);
   assign wr_cmpl_p0   = csr_wr_en && (csr_addr == ADDR_CMPL);
   assign wr_cmph_p0   = csr_wr_en && (csr_addr == ADDR_CMPH);
   assign rd_cycle_p0  = csr_rd_en && (csr_addr == ADDR_CYCLE);
   assign rd_cycleh_p0 = csr_rd_en && (csr_addr == ADDR_CYCLEH);
   assign match_p0     = (count >= cmp);

   // Clear bit (1) is an action and always reads back as 0.
   assign ctrl_view_p0 = {28'd0, pending, irq_en, 1'b0, inhibit};

   // A stall must hold the counter in the very cycle it is raised.
   assign count_keep = stall | inhibit;

   always_comb begin
      rd_mux_p0 = 32'd0;
      case (csr_addr)
         ADDR_CYCLE:  rd_mux_p0 = count[31:0];
         ADDR_CYCLEH: rd_mux_p0 = shadow_valid ? shadow : count[63:32];
         ADDR_CMPL:   rd_mux_p0 = cmp[31:0];
         ADDR_CMPH:   rd_mux_p0 = cmp[63:32];
         ADDR_CTRL:   rd_mux_p0 = ctrl_view_p0;
         default:     rd_mux_p0 = 32'd0;
      endcase
   end

   // ---- stage p1: registered read response and clear pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csr_rd_valid <= 1'b0;
         csr_rdata    <= 32'd0;
         count_clear  <= 1'b0;
      end else begin
         csr_rd_valid <= csr_rd_en;
         if (csr_rd_en)
            csr_rdata <= rd_mux_p0;
         count_clear <= wr_ctrl_p0 && csr_wdata[1];
      end
   end

   // Shadow of the upper count half. A clear invalidates it so a later CYCLEH
   // read cannot return a pre-clear upper half.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow       <= 32'd0;
         shadow_valid <= 1'b0;
      end else begin
         if (rd_cycle_p0)
            shadow <= count[63:32];
         if (wr_ctrl_p0 && csr_wdata[1])
            shadow_valid <= 1'b0;
         else if (rd_cycle_p0)
            shadow_valid <= 1'b1;
         else if (rd_cycleh_p0)
            shadow_valid <= 1'b0;
      end
   end

   // CTRL and compare registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inhibit <= 1'b0;
         irq_en  <= 1'b0;
         cmp     <= 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
         if (wr_ctrl_p0) begin
            inhibit <= csr_wdata[0];
            irq_en  <= csr_wdata[2];
         end
         if (wr_cmpl_p0)
            cmp[31:0] <= csr_wdata;
         if (wr_cmph_p0)
            cmp[63:32] <= csr_wdata;
      end
   end

   // Pending priority: compare write clears > live match sets > W1C clears.
   // The match uses the compare value in effect this cycle (pre-write).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
      end else if (wr_cmpl_p0 || wr_cmph_p0) begin
         pending <= 1'b0;
      end else if (match_p0) begin
         pending <= 1'b1;
      end else if (wr_ctrl_p0 && csr_wdata[3]) begin
         pending <= 1'b0;
      end
   end

   // ---- stage p2: interrupt level, one cycle behind pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cmp_irq <= 1'b0;
      else
         cmp_irq <= pending & irq_en;
   end

endmodule
